// File: rtl/cpu_boot_if.sv
// cpu_boot_if: host/CPU-side handshake and status bundle for cpu_boot_seq
interface cpu_boot_if;
  logic        load_req;
  logic        halt_req;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  cpu_rst;
  logic [15:0] par;
  logic        boot_done;
  logic [10:0] word_cnt;
  logic        busy;
  logic        err;
  modport master (
    output load_req, halt_req, wr_data, wr_valid,
    input  wr_ready, cpu_rst, par, boot_done, word_cnt, busy, err
  );
  modport slave (
    input  load_req, halt_req, wr_data, wr_valid,
    output wr_ready, cpu_rst, par, boot_done, word_cnt, busy, err
  );
endinterface

// File: rtl/cpu_boot_seq.sv
// cpu_boot_seq: streams host code words into the CPU and releases it to run; define CPU_BOOT_CKSUM_EN for the trailer checksum check
module cpu_boot_seq #(
  parameter int          BOOT_WORDS = 1024,
  parameter logic [15:0] NOP_WORD   = 16'h8000
) (
  input logic       clk,
  input logic       rst_n,
  cpu_boot_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, SYNC, RUN, ERROR} state_e;
  localparam logic [10:0] LAST = 11'(BOOT_WORDS - 1);
  state_e      state_q, state_d;
  logic [10:0] word_cnt_q, word_cnt_d;
  logic        err_q, err_d;
  logic [1:0]  cpu_rst_q;
  logic        wr_ready_q, boot_done_q, busy_q;
  logic        start;
`ifdef CPU_BOOT_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;
  localparam state_e FULL_ST = CHECK;
`else
  localparam state_e FULL_ST = SYNC;
`endif
  assign start = bus.load_req && !bus.halt_req;
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
`ifdef CPU_BOOT_CKSUM_EN
    cksum_d    = cksum_q;
`endif
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (bus.halt_req) begin
          state_d = IDLE;
        end else if (bus.load_req) begin
          state_d    = LOAD;
          word_cnt_d = '0;
          err_d      = (state_q == ERROR) ? 1'b0 : err_q;
`ifdef CPU_BOOT_CKSUM_EN
          cksum_d    = '0;
`endif
        end
      end
      LOAD: begin
        if (bus.halt_req) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!bus.wr_valid) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          // the 11-bit count wraps at 2048, so completion is keyed off the pre-increment value
          word_cnt_d = word_cnt_q + 11'd1;
          state_d    = (word_cnt_q == LAST) ? FULL_ST : LOAD;
`ifdef CPU_BOOT_CKSUM_EN
          cksum_d    = cksum_q + bus.wr_data;
`endif
        end
      end
`ifdef CPU_BOOT_CKSUM_EN
      CHECK: begin
        if (bus.halt_req) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (bus.wr_valid) begin
          state_d = (bus.wr_data == cksum_q) ? SYNC : ERROR;
          err_d   = err_q || (bus.wr_data != cksum_q);
        end
      end
`endif
      SYNC: begin
        state_d = bus.halt_req ? IDLE : RUN;
        err_d   = err_q || bus.halt_req;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      err_q       <= 1'b0;
      cpu_rst_q   <= 2'b00;
      wr_ready_q  <= 1'b0;
      boot_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      err_q       <= err_d;
      cpu_rst_q   <= (state_d == LOAD) ? 2'b01 : (state_d == SYNC || state_d == RUN) ? 2'b10 : 2'b00;
      wr_ready_q  <= (state_d == LOAD) || (state_d == CHECK);
      boot_done_q <= (state_d == SYNC);
      busy_q      <= (state_d == LOAD) || (state_d == CHECK) || (state_d == SYNC);
    end
  end
`ifdef CPU_BOOT_CKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cksum_q <= '0;
    else        cksum_q <= cksum_d;
  end
`endif
  assign bus.par       = (state_q == LOAD) ? bus.wr_data : NOP_WORD;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.boot_done = boot_done_q;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  logic unused_start;
  assign unused_start = start;
endmodule

// File: tb/tb_cpu_boot_seq.sv
// tb_cpu_boot_seq: scoreboard bench for a 4-word and a 2048-word loader instance
module tb_cpu_boot_seq;
  localparam logic [15:0] NOP = 16'h8000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cpu_boot_if b4 ();
  cpu_boot_if bk ();
  cpu_boot_seq #(.BOOT_WORDS(4))    u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  cpu_boot_seq #(.BOOT_WORDS(2048)) uk (.clk(clk), .rst_n(rst_n), .bus(bk));
  typedef struct {
    string       name;
    bit          sel;
    logic [1:0]  cr;
    logic        bd;
    logic [10:0] wc;
    logic        bz;
    logic        er;
    logic        rd;
    logic [15:0] p;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic step(input bit s, input logic ld, input logic hl, input logic v, input logic [15:0] d);
    @(posedge clk);
    #1;
    if (s) begin
      bk.load_req = ld; bk.halt_req = hl; bk.wr_valid = v; bk.wr_data = d;
    end else begin
      b4.load_req = ld; b4.halt_req = hl; b4.wr_valid = v; b4.wr_data = d;
    end
  endtask
  task automatic chk(input string n, input bit s, input logic [1:0] cr, input logic bd, input logic [10:0] wc,
                     input logic bz, input logic er, input logic rd, input logic [15:0] p);
    exp_t e;
    e.name = n; e.sel = s; e.cr = cr; e.bd = bd; e.wc = wc; e.bz = bz; e.er = er; e.rd = rd; e.p = p;
    q.push_back(e);
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    logic [32:0] got, want;
    if (q.size() > 0) begin
      e = q.pop_front();
      got  = e.sel ? {bk.cpu_rst, bk.boot_done, bk.word_cnt, bk.busy, bk.err, bk.wr_ready, bk.par}
                   : {b4.cpu_rst, b4.boot_done, b4.word_cnt, b4.busy, b4.err, b4.wr_ready, b4.par};
      want = {e.cr, e.bd, e.wc, e.bz, e.er, e.rd, e.p};
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got cpu_rst=%b boot_done=%b word_cnt=%0d busy=%b err=%b wr_ready=%b par=%h; want cpu_rst=%b boot_done=%b word_cnt=%0d busy=%b err=%b wr_ready=%b par=%h",
                 e.name, got[32:31], got[30], got[29:19], got[18], got[17], got[16], got[15:0],
                 e.cr, e.bd, e.wc, e.bz, e.er, e.rd, e.p);
      end
    end
  end
  initial begin
    b4.load_req = 0; b4.halt_req = 0; b4.wr_valid = 0; b4.wr_data = '0;
    bk.load_req = 0; bk.halt_req = 0; bk.wr_valid = 0; bk.wr_data = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset", 0, 2'b00, 0, 0, 0, 0, 0, NOP);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(0, 1, 0, 0, 16'h0);    chk("idle",     0, 2'b00, 0, 0, 0, 0, 0, NOP);
    step(0, 0, 0, 1, 16'h1);    chk("load_w1",  0, 2'b01, 0, 0, 1, 0, 1, 16'h1);
    step(0, 0, 0, 1, 16'h2);    chk("load_w2",  0, 2'b01, 0, 1, 1, 0, 1, 16'h2);
    step(0, 0, 0, 1, 16'h3);    chk("load_w3",  0, 2'b01, 0, 2, 1, 0, 1, 16'h3);
    step(0, 0, 0, 1, 16'h4);    chk("load_w4",  0, 2'b01, 0, 3, 1, 0, 1, 16'h4);
`ifdef CPU_BOOT_CKSUM_EN
    step(0, 0, 0, 1, 16'h000A); chk("check",    0, 2'b00, 0, 4, 1, 0, 1, NOP);
`endif
    step(0, 0, 0, 0, 16'h0);    chk("sync",     0, 2'b10, 1, 4, 1, 0, 0, NOP);
    step(0, 0, 1, 0, 16'h0);    chk("run",      0, 2'b10, 0, 4, 0, 0, 0, NOP);
    step(0, 0, 0, 0, 16'h0);    chk("halt_run", 0, 2'b00, 0, 4, 0, 0, 0, NOP);
    step(0, 1, 0, 0, 16'h0);    chk("idle2",    0, 2'b00, 0, 4, 0, 0, 0, NOP);
    step(0, 0, 0, 1, 16'h11);   chk("gap_w1",   0, 2'b01, 0, 0, 1, 0, 1, 16'h11);
    step(0, 0, 0, 1, 16'h12);   chk("gap_w2",   0, 2'b01, 0, 1, 1, 0, 1, 16'h12);
    step(0, 0, 0, 0, 16'h0);    chk("gap",      0, 2'b01, 0, 2, 1, 0, 1, 16'h0);
    step(0, 1, 0, 0, 16'h0);    chk("gap_err",  0, 2'b00, 0, 2, 0, 1, 0, NOP);
    step(0, 0, 0, 1, 16'h21);   chk("reload",   0, 2'b01, 0, 0, 1, 0, 1, 16'h21);
    step(0, 1, 1, 0, 16'h0);    chk("halt_ld",  0, 2'b01, 0, 1, 1, 0, 1, 16'h0);
    step(0, 0, 0, 0, 16'h0);    chk("abort",    0, 2'b00, 0, 1, 0, 1, 0, NOP);
    step(0, 1, 0, 0, 16'h0);    chk("idle_err", 0, 2'b00, 0, 1, 0, 1, 0, NOP);
    step(0, 0, 0, 1, 16'h31);
    step(0, 0, 0, 1, 16'h32);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 0, 2'b00, 0, 0, 0, 0, 0, NOP);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 1, 16'h40);   chk("post_rst",  0, 2'b00, 0, 0, 0, 0, 0, NOP);
    step(0, 0, 0, 0, 16'h0);    chk("post_rst2", 0, 2'b00, 0, 0, 0, 0, 0, NOP);
`ifdef CPU_BOOT_CKSUM_EN
    step(0, 1, 0, 0, 16'h0);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 16'(i));
    step(0, 0, 0, 1, 16'h000B); chk("check_b",   0, 2'b00, 0, 4, 1, 0, 1, NOP);
    step(0, 0, 0, 0, 16'h0);    chk("cksum_bad", 0, 2'b00, 0, 4, 0, 1, 0, NOP);
`endif
    step(1, 1, 0, 0, 16'h0);    chk("big_idle", 1, 2'b00, 0, 0, 0, 0, 0, NOP);
    for (int i = 0; i < 2048; i++) begin
      step(1, 0, 0, 1, 16'(i));
      if (i == 0 || i == 1024 || i == 2047) chk("big_load", 1, 2'b01, 0, 11'(i), 1, 0, 1, 16'(i));
    end
`ifdef CPU_BOOT_CKSUM_EN
    step(1, 0, 0, 1, 16'hFC00); chk("big_check", 1, 2'b00, 0, 0, 1, 0, 1, NOP);
`endif
    step(1, 0, 0, 0, 16'h0);    chk("big_sync", 1, 2'b10, 1, 0, 1, 0, 0, NOP);
    step(1, 0, 0, 0, 16'h0);    chk("big_run",  1, 2'b10, 0, 0, 0, 0, 0, NOP);
    step(1, 0, 0, 0, 16'h0);    chk("big_run2", 1, 2'b10, 0, 0, 0, 0, 0, NOP);
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
